// File: rtl/clock_pkg.sv
// Shared definitions for the clock-frequency request path: divisor word layout,
// legal quotient range, error codes and the sequencer state encoding.
package clock_pkg;

    localparam int DIV_FRAC_LSB  = 8;
    localparam int DIV_FRAC_STEP = 125;
    localparam int Q_MIN         = 8;
    localparam int Q_MAX         = 2047;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ZERO    = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIVIDE,
        S_CHECK,
        S_CONFIG,
        S_WAIT_ACK,
        S_SETTLE,
        S_DONE,
        S_FAIL
    } state_t;

    // q is divisor x 8: integer part in q[10:3], eighths encoded as thousandths.
    function automatic logic [31:0] make_div_word(input logic [10:0] q);
        logic [9:0] frac;
        frac = 10'(q[2:0]) * 10'(DIV_FRAC_STEP);
        return (32'(frac) << DIV_FRAC_LSB) | 32'(q[10:3]);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Multicycle restoring divider: one quotient bit per clock, WIDTH clocks per divide.
// done is high during the final step; quotient is valid from the following cycle.
module seq_divider #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;

    assign trial    = {rem, quo[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs};
    assign ge       = trial >= {1'b0, dvs};
    assign done     = (cnt == CNT_W'(1));
    assign quotient = quo;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Dividend bits shift out of quo as quotient bits shift in.
    always_ff @(posedge clk) begin
        if (start) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (cnt != '0) begin
            quo <= {quo[WIDTH-2:0], ge};
            rem <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/clock_freq_request.sv
// Converts a kHz frequency request into a clock-wizard divisor word, hands it to
// clock_mgr, waits for the readback to match, settles, then reports done/err.
module clock_freq_request
    import clock_pkg::*;
#(
    parameter int VCO_KHZ        = 1_200_000,
    parameter int SETTLE_CYCLES  = 4096,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_khz,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] result_div,
    output logic [31:0] div_in,
    output logic        configure,
    input  logic [31:0] div_out
);

    localparam logic [39:0] VCO_X8 = 40'(VCO_KHZ) * 40'd8;

    state_t      state, state_next;
    logic [31:0] cnt, cnt_next;
    logic [1:0]  err_code_next;
    logic        div_start;
    logic        div_done;
    logic        load_result;
    logic [39:0] quotient;
    logic [39:0] dividend;
    logic        q_in_range;

    // Adding half the divisor turns the floored quotient into round-to-nearest.
    assign dividend   = VCO_X8 + 40'(req_khz >> 1);
    assign q_in_range = (quotient >= 40'(Q_MIN)) && (quotient <= 40'(Q_MAX));

    seq_divider #(.WIDTH(40)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  ({8'd0, req_khz}),
        .done     (div_done),
        .quotient (quotient)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            err_code   <= ERR_NONE;
            result_div <= '0;
            div_in     <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            err_code <= err_code_next;
            // div_in is held between successful checks; clock_mgr may sample it late.
            if (load_result) begin
                result_div <= make_div_word(quotient[10:0]);
                div_in     <= make_div_word(quotient[10:0]);
            end
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        err_code_next = err_code;
        div_start     = 1'b0;
        load_result   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        configure     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_khz == 32'd0) begin
                        err_code_next = ERR_ZERO;
                        state_next    = S_FAIL;
                    end else begin
                        err_code_next = ERR_NONE;
                        div_start     = 1'b1;
                        state_next    = S_DIVIDE;
                    end
                end
            end
            S_DIVIDE: begin
                busy = 1'b1;
                if (div_done) state_next = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (!q_in_range) begin
                    err_code_next = ERR_RANGE;
                    state_next    = S_FAIL;
                end else begin
                    load_result = 1'b1;
                    state_next  = S_CONFIG;
                end
            end
            S_CONFIG: begin
                busy       = 1'b1;
                configure  = 1'b1;
                cnt_next   = '0;
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                busy = 1'b1;
                if (div_out == div_in) begin
                    cnt_next   = '0;
                    state_next = S_SETTLE;
                end else if (cnt == 32'(TIMEOUT_CYCLES)) begin
                    err_code_next = ERR_TIMEOUT;
                    state_next    = S_FAIL;
                end else begin
                    cnt_next = cnt + 32'd1;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == 32'(SETTLE_CYCLES - 1)) state_next = S_DONE;
                else cnt_next = cnt + 32'd1;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_FAIL: begin
                err        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clock_freq_request.sv
// Directed bench for clock_freq_request with a small clock_mgr model that copies
// div_in to div_out a fixed number of cycles after each configure pulse.
module tb_clock_freq_request;

    localparam int TB_SETTLE  = 40;
    localparam int TB_TIMEOUT = 300;
    localparam int ACK_DELAY  = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_khz;
    logic        busy, done, err, configure;
    logic [1:0]  err_code;
    logic [31:0] result_div, div_in;
    logic [31:0] div_out = 32'd0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        ack_en = 1'b1;
    logic [31:0] pend = 32'd0;
    int          ack_cnt = 0;

    clock_freq_request #(
        .VCO_KHZ        (1_200_000),
        .SETTLE_CYCLES  (TB_SETTLE),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_khz    (req_khz),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .result_div (result_div),
        .div_in     (div_in),
        .configure  (configure),
        .div_out    (div_out)
    );

    always #5 clk = ~clk;

    // clock_mgr model: new word visible ACK_DELAY cycles after the configure cycle.
    always @(posedge clk) begin
        if (configure && ack_en) begin
            pend    <= div_in;
            ack_cnt <= ACK_DELAY - 1;
        end else if (ack_cnt != 0) begin
            if (ack_cnt == 1) div_out <= pend;
            ack_cnt <= ack_cnt - 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request for one cycle (cycle T); returns in cycle T+1.
    task automatic accept(input logic [31:0] khz);
        req_valid = 1'b1;
        req_khz   = khz;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if ({busy, done, err, configure} !== 4'b0000 || err_code !== 2'd0 ||
            result_div !== 32'd0 || div_in !== 32'd0) begin
            tests_failed++;
            $display("FAIL %s: busy=%0b done=%0b err=%0b cfg=%0b code=%0d res=%h div_in=%h, want all zero",
                     tag, busy, done, err, configure, err_code, result_div, div_in);
        end
    endtask

    // Waits from the configure cycle for done (or err); returns cycles elapsed.
    task automatic wait_end(input bit want_err, output int k, output int cfg_seen);
        bit got;
        got = 1'b0;
        k = 0;
        cfg_seen = 0;
        while (!got && k < TB_TIMEOUT + TB_SETTLE + 100) begin
            step(1);
            k++;
            if (configure) cfg_seen++;
            if (want_err ? err : done) got = 1'b1;
        end
        if (!got) k = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0;
        req_khz = 32'd0;
        step(3);
        check_reset_outputs("reset_values");
        reset = 1'b0;
        step(1);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_basic;
        int k, c;
        accept(32'd100000);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_t1: got %0b want 1", busy); end
        step(40);
        tests_run++;
        if (configure !== 1'b0) begin tests_failed++; $display("FAIL basic_cfg_t41: got %0b want 0", configure); end
        step(1);
        tests_run++;
        if (configure !== 1'b1 || div_in !== 32'h0000000C) begin
            tests_failed++;
            $display("FAIL basic_cfg_t42: cfg=%0b div_in=%h want 1 / 0000000c", configure, div_in);
        end
        wait_end(1'b0, k, c);
        tests_run++;
        if (k != ACK_DELAY + TB_SETTLE + 1) begin
            tests_failed++;
            $display("FAIL basic_done_latency: got %0d want %0d", k, ACK_DELAY + TB_SETTLE + 1);
        end
        tests_run++;
        if (busy !== 1'b0 || err !== 1'b0 || result_div !== 32'h0000000C || c != 0) begin
            tests_failed++;
            $display("FAIL basic_done_state: busy=%0b err=%0b res=%h cfg_extra=%0d want 0/0/0000000c/0",
                     busy, err, result_div, c);
        end
        step(1);
    endtask

    task automatic test_fraction;
        int k, c;
        accept(32'd250000);
        step(41);
        tests_run++;
        if (configure !== 1'b1 || div_in !== 32'h0002EE04) begin
            tests_failed++;
            $display("FAIL frac_cfg: cfg=%0b div_in=%h want 1 / 0002ee04", configure, div_in);
        end
        wait_end(1'b0, k, c);
        tests_run++;
        if (k != ACK_DELAY + TB_SETTLE + 1 || result_div !== 32'h0002EE04 || err_code !== 2'd0) begin
            tests_failed++;
            $display("FAIL frac_done: lat=%0d res=%h code=%0d want %0d / 0002ee04 / 0",
                     k, result_div, err_code, ACK_DELAY + TB_SETTLE + 1);
        end
        step(1);
    endtask

    task automatic test_range;
        logic [31:0] khz [2];
        int cfg_seen;
        khz[0] = 32'd4000;
        khz[1] = 32'd2000000;
        for (int r = 0; r < 2; r++) begin
            cfg_seen = 0;
            accept(khz[r]);
            if (configure) cfg_seen++;
            for (int i = 2; i <= 42; i++) begin
                step(1);
                if (configure) cfg_seen++;
                if (i == 41) begin
                    tests_run++;
                    if (err !== 1'b0) begin tests_failed++; $display("FAIL range%0d_err_early: got %0b want 0", r, err); end
                end
            end
            tests_run++;
            if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL range%0d_err_t42: err=%0b code=%0d busy=%0b want 1/2/0", r, err, err_code, busy);
            end
            tests_run++;
            if (cfg_seen != 0 || div_in !== 32'h0002EE04) begin
                tests_failed++;
                $display("FAIL range%0d_no_config: cfg=%0d div_in=%h want 0 / 0002ee04", r, cfg_seen, div_in);
            end
            step(1);
            tests_run++;
            if (err !== 1'b0 || err_code !== 2'd2) begin
                tests_failed++;
                $display("FAIL range%0d_code_held: err=%0b code=%0d want 0/2", r, err, err_code);
            end
        end
    endtask

    task automatic test_zero;
        accept(32'd0);
        tests_run++;
        if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_err_t1: err=%0b code=%0d busy=%0b want 1/1/0", err, err_code, busy);
        end
        step(1);
        tests_run++;
        if (err !== 1'b0 || busy !== 1'b0 || err_code !== 2'd1) begin
            tests_failed++;
            $display("FAIL zero_after: err=%0b busy=%0b code=%0d want 0/0/1", err, busy, err_code);
        end
    endtask

    task automatic test_timeout;
        int k, cfg_seen;
        bit got;
        ack_en = 1'b0;
        accept(32'd100000);
        step(41);
        tests_run++;
        if (configure !== 1'b1) begin tests_failed++; $display("FAIL timeout_cfg: got %0b want 1", configure); end
        got = 1'b0;
        k = 0;
        cfg_seen = 0;
        while (!got && k < TB_TIMEOUT + 50) begin
            req_valid = (k == 5);
            req_khz   = 32'd250000;
            step(1);
            k++;
            if (configure) cfg_seen++;
            if (err) got = 1'b1;
        end
        req_valid = 1'b0;
        tests_run++;
        if (!got || k != TB_TIMEOUT + 2 || err_code !== 2'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err: seen=%0b lat=%0d code=%0d busy=%0b want 1/%0d/3/0",
                     got, k, err_code, busy, TB_TIMEOUT + 2);
        end
        step(3);
        if (configure) cfg_seen++;
        tests_run++;
        if (cfg_seen != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_ignored_req: extra_cfg=%0d busy=%0b want 0/0", cfg_seen, busy);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_midop;
        int k, c;
        accept(32'd100000);
        step(9);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_divide_busy: got %0b want 1", busy); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_reset_outputs("rst_in_divide");
        step(1);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_divide_idle: busy=%0b want 0", busy); end

        accept(32'd100000);
        step(41);
        tests_run++;
        if (configure !== 1'b1) begin tests_failed++; $display("FAIL rst_settle_cfg: got %0b want 1", configure); end
        step(ACK_DELAY + 5);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_settle_busy: busy=%0b done=%0b want 1/0", busy, done);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_reset_outputs("rst_in_settle");

        // div_out already holds 0x0C, so the readback matches immediately.
        accept(32'd100000);
        step(41);
        tests_run++;
        if (configure !== 1'b1 || div_in !== 32'h0000000C) begin
            tests_failed++;
            $display("FAIL post_rst_cfg: cfg=%0b div_in=%h want 1 / 0000000c", configure, div_in);
        end
        wait_end(1'b0, k, c);
        tests_run++;
        if (k != TB_SETTLE + 2 || result_div !== 32'h0000000C || err_code !== 2'd0) begin
            tests_failed++;
            $display("FAIL post_rst_done: lat=%0d res=%h code=%0d want %0d / 0000000c / 0",
                     k, result_div, err_code, TB_SETTLE + 2);
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_range();
        test_zero();
        test_timeout();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clock_freq_request.md
# clock_freq_request

Upstream sequencer for `clock_mgr`. It accepts a requested output frequency in kHz and converts it to a PG065 clock-wizard divisor word with a multicycle restoring divider. It then strobes `configure` into `clock_mgr`, waits until `div_out` reflects the new word, and reports completion after a settle interval. This gives software and control logic a single "set frequency" handshake in place of raw divisor arithmetic.

## Interface
- `VCO_KHZ`, 1_200_000: VCO frequency in kHz; constant for the build.
- `SETTLE_CYCLES`, 4096: `clk` cycles to wait after the divisor is acknowledged, before `done`.
- `TIMEOUT_CYCLES`, 65535: maximum cycles to wait for `div_out` to match.
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request strobe; sampled only in IDLE.
- `req_khz` in 32: requested output frequency in kHz.
- `busy` out 1: high from the cycle after acceptance until the cycle `done`/`err` pulses.
- `done` out 1: one-cycle pulse; the new frequency is applied.
- `err` out 1: one-cycle pulse; the request failed.
- `err_code` out 2: 0 = none, 1 = zero request, 2 = out of range, 3 = timeout. Held until the next acceptance.
- `result_div` out 32: last computed divisor word. Held until the next acceptance.
- `div_in` out 32: to `clock_mgr.div_in`.
- `configure` out 1: to `clock_mgr.configure`; one-cycle pulse.
- `div_out` in 32: from `clock_mgr.div_out`.

## Operation
- Arithmetic is in eighths of a divide step. The wizard fraction granularity is 0.125, encoded as thousandths (0..875).
  - N = (VCO_KHZ << 3) + (req_khz >> 1), 40-bit.
  - Q = floor(N / req_khz), i.e. divisor × 8 rounded to nearest.
- Legal range is 8 ≤ Q ≤ 2047, i.e. integer part 1..255.
- Divisor word layout: bits [7:0] = Q[10:3]; bits [17:8] = Q[2:0] × 125; bits [31:18] = 0.
- States:
  - IDLE: on `req_valid`, latch `req_khz` and clear `err_code`. If `req_khz` == 0, go to FAIL with code 1. Otherwise load the divider and go to DIVIDE.
  - DIVIDE: restoring divide, one quotient bit per cycle, 40 cycles. Then go to CHECK.
  - CHECK: if Q is out of range, go to FAIL with code 2. Otherwise register `result_div` and `div_in` and go to CONFIG.
  - CONFIG: pulse `configure`, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: when `div_out` == `div_in`, go to SETTLE. If the counter reaches `TIMEOUT_CYCLES`, go to FAIL with code 3.
  - SETTLE: count `SETTLE_CYCLES`, then go to DONE.
  - DONE: pulse `done`, return to IDLE.
  - FAIL: pulse `err`, return to IDLE.
- If the new word equals the current `div_out`, WAIT_ACK exits on its first cycle; `clock_mgr` still performs the write.
- `req_valid` while `busy` is ignored; no queueing.

## Timing
- Reset values:
  - `busy`, `done`, `err`, `configure` = 0.
  - `err_code` = 0.
  - `result_div` = 0.
  - `div_in` = 0.
  - state = IDLE.
- Acceptance at cycle T:
  - `busy` = 1 at T+1.
  - DIVIDE occupies T+1..T+40.
  - CHECK at T+41.
  - `configure` high at T+42 with `div_in` already stable since T+42.
- `div_in` holds its value from CHECK until the next successful CHECK, because `clock_mgr` may sample it late.
- Zero request: `err` at T+1, `busy` never asserted.
- Range error: `err` at T+42.
- `done` follows the first matching `div_out` cycle by exactly `SETTLE_CYCLES` + 1 cycles.
- `busy` deasserts in the same cycle that `done`/`err` pulses. A new request is accepted the following cycle.
- Reset mid-operation: return to IDLE immediately with outputs at reset values. Any write already issued by `clock_mgr` completes on its own; the block does not track it.

## Structure
- Shared package `clock_pkg`:
  - `DIV_FRAC_LSB` = 8.
  - `DIV_FRAC_STEP` = 125.
  - `Q_MIN` = 8, `Q_MAX` = 2047.
  - err_code constants.
  - state enum.
- One sub-module: `seq_divider`, a 40-bit restoring divider with start/done. Reusable for a future achieved-frequency readback.

## Test plan
- Request 100000 kHz with `clock_mgr` model acking after 20 cycles → `div_in` = 0x0000000C, `configure` at T+42, `done` 20 + `SETTLE_CYCLES` + 1 cycles after `configure`.
- Request 250000 kHz → `result_div` = 0x0002EE04 (int 4, frac 750), `done` pulses, `err_code` = 0.
- Requests 4000 kHz (Q = 2400) and 2000000 kHz (Q = 5) → each `err` at T+42 with `err_code` = 2, no `configure` pulse, `div_in` unchanged.
- Request 0 → `err` at T+1, `err_code` = 1, `busy` stays 0.
- Model never updates `div_out` → `err` with `err_code` = 3 after `TIMEOUT_CYCLES`. A second `req_valid` during `busy` produces no extra `configure`.
- Assert `reset` in DIVIDE and again in SETTLE → all outputs return to reset values the next cycle. A subsequent 100000 kHz request completes normally.
